// File: rtl/chess_clock_bank.sv
// Multi-player chess clock: per-player min:sec countdown, set-up editing,
// Fischer increment on turn switch, pause and sticky timeout flags.
module chess_clock_bank #(
    parameter int NUM_PLAYERS = 2,
    parameter int MIN_MAX     = 99,
    parameter int INIT_MIN    = 5,
    parameter int INC_SEC     = 0,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     clear,
    input  logic                     switch_turn,
    input  logic                     add_min,
    input  logic                     add_sec,
    input  logic [PW-1:0]            sel,
    output logic [NUM_PLAYERS*7-1:0] minutes,
    output logic [NUM_PLAYERS*6-1:0] seconds,
    output logic [PW-1:0]            active,
    output logic [1:0]               state,
    output logic [NUM_PLAYERS-1:0]   flag,
    output logic                     expired
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_RUN     = 2'b01;
    localparam logic [1:0] S_PAUSE   = 2'b10;
    localparam logic [1:0] S_TIMEOUT = 2'b11;

    localparam logic [6:0] L_MAX  = 7'(MIN_MAX);
    localparam logic [6:0] L_INIT = 7'(INIT_MIN);
    localparam logic [6:0] L_INC  = 7'(INC_SEC);
    localparam logic [PW-1:0] L_LAST = PW'(NUM_PLAYERS - 1);

    logic [6:0]             r_min [NUM_PLAYERS];
    logic [5:0]             r_sec [NUM_PLAYERS];
    logic [PW-1:0]          r_active;
    logic [1:0]             r_state;
    logic [NUM_PLAYERS-1:0] r_flag;
    logic                   r_expired;

    logic [6:0]    w_cur_min, w_tk_min, w_b_min, w_bn_min;
    logic [5:0]    w_cur_sec, w_tk_sec, w_b_sec, w_bn_sec;
    logic [6:0]    w_sum;
    logic [7:0]    w_min_ext;
    logic          w_tk_exp, w_sel_ok, w_any_zero;
    logic [PW-1:0] w_nxt_act;

    assign w_cur_min = r_min[r_active];
    assign w_cur_sec = r_sec[r_active];

    always_comb begin
        w_tk_min = w_cur_min;
        w_tk_sec = w_cur_sec;
        if (w_cur_sec != 6'd0) begin
            w_tk_sec = w_cur_sec - 6'd1;
        end else if (w_cur_min != 7'd0) begin
            w_tk_min = w_cur_min - 7'd1;
            w_tk_sec = 6'd59;
        end
    end

    assign w_tk_exp = (w_tk_min == 7'd0) && (w_tk_sec == 6'd0);

    // Bonus applies on top of a same-cycle tick when running
    assign w_b_min = (r_state == S_RUN && tick) ? w_tk_min : w_cur_min;
    assign w_b_sec = (r_state == S_RUN && tick) ? w_tk_sec : w_cur_sec;
    assign w_sum   = {1'b0, w_b_sec} + L_INC;

    always_comb begin
        w_bn_sec  = w_sum[5:0];
        w_min_ext = {1'b0, w_b_min};
        if (w_sum >= 7'd60) begin
            w_bn_sec  = 6'(w_sum - 7'd60);
            w_min_ext = {1'b0, w_b_min} + 8'd1;
        end
        w_bn_min = w_min_ext[6:0];
        if (w_min_ext > {1'b0, L_MAX}) begin
            w_bn_min = L_MAX;
            w_bn_sec = 6'd59;
        end
    end

    assign w_nxt_act = (r_active == L_LAST) ? '0 : r_active + PW'(1);
    assign w_sel_ok  = {1'b0, sel} < (PW + 1)'(NUM_PLAYERS);

    always_comb begin
        w_any_zero = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (r_min[p] == 7'd0 && r_sec[p] == 6'd0) w_any_zero = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_min[p] <= L_INIT;
                r_sec[p] <= 6'd0;
            end
            r_active  <= '0;
            r_state   <= S_IDLE;
            r_flag    <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (clear) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    r_min[p] <= L_INIT;
                    r_sec[p] <= 6'd0;
                end
                r_active <= '0;
                r_state  <= S_IDLE;
                r_flag   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_sel_ok) begin
                            if (add_min)
                                r_min[sel] <= (r_min[sel] >= L_MAX) ? 7'd0 : r_min[sel] + 7'd1;
                            if (add_sec)
                                r_sec[sel] <= (r_sec[sel] >= 6'd59) ? 6'd0 : r_sec[sel] + 6'd1;
                            if (start && !w_any_zero) begin
                                r_active <= sel;
                                r_state  <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (tick && w_tk_exp) begin
                            r_min[r_active]  <= w_tk_min;
                            r_sec[r_active]  <= w_tk_sec;
                            r_flag[r_active] <= 1'b1;
                            r_expired        <= 1'b1;
                            r_state          <= S_TIMEOUT;
                        end else begin
                            if (switch_turn) begin
                                r_min[r_active] <= w_bn_min;
                                r_sec[r_active] <= w_bn_sec;
                                r_active        <= w_nxt_act;
                            end else if (tick) begin
                                r_min[r_active] <= w_tk_min;
                                r_sec[r_active] <= w_tk_sec;
                            end
                            if (pause) r_state <= S_PAUSE;
                        end
                    end
                    S_PAUSE: begin
                        if (switch_turn) begin
                            r_min[r_active] <= w_bn_min;
                            r_sec[r_active] <= w_bn_sec;
                            r_active        <= w_nxt_act;
                        end
                        if (pause) r_state <= S_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_out
        assign minutes[7*g +: 7] = r_min[g];
        assign seconds[6*g +: 6] = r_sec[g];
    end

    assign active  = r_active;
    assign state   = r_state;
    assign flag    = r_flag;
    assign expired = r_expired;

endmodule

// File: tb/tb_chess_clock_bank.sv
// Directed bench for chess_clock_bank: one DUT with no increment,
// one with a 5 s Fischer increment, driven by shared stimulus.
module tb_chess_clock_bank;

    logic clk = 1'b0;
    logic reset;
    logic tick, start, pause, clear, switch_turn, add_min, add_sec;
    logic sel;

    logic [13:0] min0, min5;
    logic [11:0] sec0, sec5;
    logic        act0, act5;
    logic [1:0]  st0, st5;
    logic [1:0]  flg0, flg5;
    logic        exp0, exp5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chess_clock_bank #(.NUM_PLAYERS(2), .MIN_MAX(99), .INIT_MIN(5), .INC_SEC(0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .switch_turn(switch_turn), .add_min(add_min),
        .add_sec(add_sec), .sel(sel), .minutes(min0), .seconds(sec0),
        .active(act0), .state(st0), .flag(flg0), .expired(exp0)
    );

    chess_clock_bank #(.NUM_PLAYERS(2), .MIN_MAX(99), .INIT_MIN(5), .INC_SEC(5)) dut5 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .switch_turn(switch_turn), .add_min(add_min),
        .add_sec(add_sec), .sel(sel), .minutes(min5), .seconds(sec5),
        .active(act5), .state(st5), .flag(flg5), .expired(exp5)
    );

    function automatic int m0(int p); return int'(min0[7*p +: 7]); endfunction
    function automatic int s0(int p); return int'(sec0[6*p +: 6]); endfunction
    function automatic int m5(int p); return int'(min5[7*p +: 7]); endfunction
    function automatic int s5(int p); return int'(sec5[6*p +: 6]); endfunction

    task automatic step();
        @(posedge clk);
        #1;
        {tick, start, pause, clear, switch_turn, add_min, add_sec} = '0;
    endtask

    task automatic addm(int n);
        for (int i = 0; i < n; i++) begin add_min = 1'b1; step(); end
    endtask

    task automatic adds(int n);
        for (int i = 0; i < n; i++) begin add_sec = 1'b1; step(); end
    endtask

    task automatic do_clear();
        clear = 1'b1; step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        reset = 1'b1;
        step();
        checks++; if (m0(0) !== 5 || s0(0) !== 0 || m0(1) !== 5 || s0(1) !== 0) begin errors++;
            $display("FAIL reset_time got %0d:%0d %0d:%0d want 5:0 5:0", m0(0), s0(0), m0(1), s0(1)); end
        checks++; if (st0 !== 2'b00 || flg0 !== 2'b00 || exp0 !== 1'b0 || act0 !== 1'b0) begin errors++;
            $display("FAIL reset_ctrl got st=%b flag=%b exp=%b act=%b want 00 00 0 0", st0, flg0, exp0, act0); end
        for (int i = 0; i < 10; i++) begin tick = 1'b1; step(); end
        checks++; if (m0(0) !== 5 || s0(0) !== 0 || st0 !== 2'b00) begin errors++;
            $display("FAIL idle_ticks got %0d:%0d st=%b want 5:0 st=00", m0(0), s0(0), st0); end
    endtask

    task automatic test_edit();
        do_clear();
        sel = 1'b1;
        adds(61);
        checks++; if (m0(1) !== 5 || s0(1) !== 1) begin errors++;
            $display("FAIL sec_wrap got %0d:%0d want 5:1", m0(1), s0(1)); end
        addm(95);
        checks++; if (m0(1) !== 0 || s0(1) !== 1) begin errors++;
            $display("FAIL min_wrap got %0d:%0d want 0:1", m0(1), s0(1)); end
        checks++; if (m0(0) !== 5 || s0(0) !== 0) begin errors++;
            $display("FAIL edit_other got %0d:%0d want 5:0", m0(0), s0(0)); end
        do_clear();
        sel = 1'b0;
        add_min = 1'b1; add_sec = 1'b1; step();
        checks++; if (m0(0) !== 6 || s0(0) !== 1) begin errors++;
            $display("FAIL edit_both got %0d:%0d want 6:1", m0(0), s0(0)); end
        start = 1'b0; tick = 1'b1; switch_turn = 1'b1; pause = 1'b1; step();
        checks++; if (st0 !== 2'b00 || act0 !== 1'b0) begin errors++;
            $display("FAIL idle_ignore got st=%b act=%b want 00 0", st0, act0); end
    endtask

    task automatic test_start_block();
        do_clear();
        sel = 1'b0;
        addm(95);
        start = 1'b1; step();
        checks++; if (st0 !== 2'b00) begin errors++;
            $display("FAIL start_zero got st=%b want 00", st0); end
    endtask

    task automatic test_timeout();
        do_clear();
        sel = 1'b0;
        addm(95);
        adds(2);
        start = 1'b1; step();
        checks++; if (st0 !== 2'b01 || act0 !== 1'b0) begin errors++;
            $display("FAIL start got st=%b act=%b want 01 0", st0, act0); end
        tick = 1'b1; step();
        checks++; if (m0(0) !== 0 || s0(0) !== 1 || exp0 !== 1'b0) begin errors++;
            $display("FAIL tick1 got %0d:%0d exp=%b want 0:1 exp=0", m0(0), s0(0), exp0); end
        tick = 1'b1; step();
        checks++; if (m0(0) !== 0 || s0(0) !== 0 || st0 !== 2'b11 || flg0 !== 2'b01 || exp0 !== 1'b1) begin errors++;
            $display("FAIL expire got %0d:%0d st=%b flag=%b exp=%b want 0:0 11 01 1", m0(0), s0(0), st0, flg0, exp0); end
        tick = 1'b1; switch_turn = 1'b1; step();
        checks++; if (exp0 !== 1'b0 || st0 !== 2'b11 || act0 !== 1'b0 || m0(1) !== 5 || s0(0) !== 0) begin errors++;
            $display("FAIL frozen got exp=%b st=%b act=%b p1min=%0d want 0 11 0 5", exp0, st0, act0, m0(1)); end
        checks++; if (flg0 !== 2'b01) begin errors++;
            $display("FAIL flag_sticky got %b want 01", flg0); end
        do_clear();
        checks++; if (m0(0) !== 5 || s0(0) !== 0 || m0(1) !== 5 || flg0 !== 2'b00 || st0 !== 2'b00) begin errors++;
            $display("FAIL clear got %0d:%0d p1=%0d flag=%b st=%b want 5:0 5 00 00", m0(0), s0(0), m0(1), flg0, st0); end
    endtask

    task automatic test_bonus();
        do_clear();
        sel = 1'b0;
        addm(96);
        adds(57);
        start = 1'b1; step();
        switch_turn = 1'b1; step();
        checks++; if (m5(0) !== 2 || s5(0) !== 2 || act5 !== 1'b1) begin errors++;
            $display("FAIL bonus_carry got %0d:%0d act=%b want 2:2 1", m5(0), s5(0), act5); end
        checks++; if (m0(0) !== 1 || s0(0) !== 57 || act0 !== 1'b1) begin errors++;
            $display("FAIL bonus_zero got %0d:%0d act=%b want 1:57 1", m0(0), s0(0), act0); end
        do_clear();
        sel = 1'b1;
        addm(94);
        adds(58);
        start = 1'b1; step();
        switch_turn = 1'b1; step();
        checks++; if (m5(1) !== 99 || s5(1) !== 59 || act5 !== 1'b0) begin errors++;
            $display("FAIL bonus_sat got %0d:%0d act=%b want 99:59 0", m5(1), s5(1), act5); end
    endtask

    task automatic test_same_cycle();
        do_clear();
        sel = 1'b0;
        addm(96);
        start = 1'b1; step();
        tick = 1'b1; switch_turn = 1'b1; step();
        checks++; if (m0(0) !== 0 || s0(0) !== 59 || act0 !== 1'b1 || st0 !== 2'b01) begin errors++;
            $display("FAIL tick_switch got %0d:%0d act=%b st=%b want 0:59 1 01", m0(0), s0(0), act0, st0); end
        checks++; if (m5(0) !== 1 || s5(0) !== 4 || act5 !== 1'b1) begin errors++;
            $display("FAIL tick_switch_inc got %0d:%0d act=%b want 1:4 1", m5(0), s5(0), act5); end
        tick = 1'b1; switch_turn = 1'b1; pause = 1'b1; step();
        checks++; if (m0(1) !== 4 || s0(1) !== 59 || act0 !== 1'b0 || st0 !== 2'b10) begin errors++;
            $display("FAIL tick_sw_pause got %0d:%0d act=%b st=%b want 4:59 0 10", m0(1), s0(1), act0, st0); end
        do_clear();
        sel = 1'b0;
        addm(95);
        adds(1);
        start = 1'b1; step();
        tick = 1'b1; switch_turn = 1'b1; pause = 1'b1; step();
        checks++; if (m0(0) !== 0 || s0(0) !== 0 || act0 !== 1'b0 || st0 !== 2'b11 || exp0 !== 1'b1) begin errors++;
            $display("FAIL expire_switch got %0d:%0d act=%b st=%b exp=%b want 0:0 0 11 1", m0(0), s0(0), act0, st0, exp0); end
    endtask

    task automatic test_pause();
        do_clear();
        sel = 1'b0;
        start = 1'b1; step();
        tick = 1'b1; step();
        pause = 1'b1; step();
        checks++; if (m0(0) !== 4 || s0(0) !== 59 || st0 !== 2'b10) begin errors++;
            $display("FAIL pause_enter got %0d:%0d st=%b want 4:59 10", m0(0), s0(0), st0); end
        for (int i = 0; i < 3; i++) begin tick = 1'b1; add_min = 1'b1; step(); end
        checks++; if (m0(0) !== 4 || s0(0) !== 59) begin errors++;
            $display("FAIL pause_hold got %0d:%0d want 4:59", m0(0), s0(0)); end
        pause = 1'b1; step();
        tick = 1'b1; step();
        checks++; if (m0(0) !== 4 || s0(0) !== 58 || st0 !== 2'b01) begin errors++;
            $display("FAIL resume got %0d:%0d st=%b want 4:58 01", m0(0), s0(0), st0); end
        tick = 1'b1; step();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (m0(0) !== 5 || s0(0) !== 0 || m0(1) !== 5 || st0 !== 2'b00 || act0 !== 1'b0) begin errors++;
            $display("FAIL async_reset got %0d:%0d p1=%0d st=%b want 5:0 5 00", m0(0), s0(0), m0(1), st0); end
        #10;
        reset = 1'b1;
        step();
    endtask

    initial begin
        {tick, start, pause, clear, switch_turn, add_min, add_sec} = '0;
        sel = 1'b0;
        reset = 1'b1;
        #1;
        test_reset();
        test_edit();
        test_start_block();
        test_timeout();
        test_bonus();
        test_same_cycle();
        test_pause();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
